// File: rtl/multi_ball_engine.sv
// Multi-ball pong engine: advances N balls once per frame strobe, resolves
// wall, paddle and miss events, keeps score, ramps speed and runs the
// IDLE/PLAY/OVER game sequence. All state moves only on refresh_tick.
module multi_ball_engine #(
    parameter int NUM_BALLS   = 3,
    parameter int BALL_SIZE   = 8,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int TOP_MARGIN  = 25,
    parameter int PADDLE_H    = 72,
    parameter int PADDLE_W    = 8,
    parameter int PADDLE_L_X  = 32,
    parameter int PADDLE_R_X  = 600,
    parameter int SPEED_MIN   = 2,
    parameter int SPEED_MAX   = 5,
    parameter int RAMP_TICKS  = 600,
    parameter int SERVE_TICKS = 60,
    parameter int WIN_SCORE   = 5
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    refresh_tick,
    input  logic                    start,
    input  logic                    pause,
    input  logic [9:0]              paddle1_y,
    input  logic [9:0]              paddle2_y,
    output logic [10*NUM_BALLS-1:0] ball_x,
    output logic [10*NUM_BALLS-1:0] ball_y,
    output logic [NUM_BALLS-1:0]    ball_active,
    output logic [3:0]              score_p1,
    output logic [3:0]              score_p2,
    output logic [3:0]              speed,
    output logic [1:0]              state,
    output logic [1:0]              winner,
    output logic                    point_p1,
    output logic                    point_p2,
    output logic                    game_over
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } game_state_t;

    localparam int SERVE_W = $clog2(SERVE_TICKS + 1);
    localparam int RAMP_W  = $clog2(RAMP_TICKS + 1);

    // Geometry in the 11-bit domain used for all position arithmetic
    localparam logic [10:0] SIZE11     = 11'(BALL_SIZE);
    localparam logic [10:0] WIDTH11    = 11'(SCREEN_W);
    localparam logic [10:0] TOP11      = 11'(TOP_MARGIN);
    localparam logic [10:0] BOTTOM11   = 11'(SCREEN_H - BALL_SIZE);
    localparam logic [10:0] LFACE11    = 11'(PADDLE_L_X + PADDLE_W);
    localparam logic [10:0] RFACE11    = 11'(PADDLE_R_X);
    localparam logic [10:0] PADH11     = 11'(PADDLE_H);

    // Positions a ball is snapped to when it bounces
    localparam logic [9:0]  TOP10      = 10'(TOP_MARGIN);
    localparam logic [9:0]  BOTTOM10   = 10'(SCREEN_H - BALL_SIZE);
    localparam logic [9:0]  LSTOP10    = 10'(PADDLE_L_X + PADDLE_W);
    localparam logic [9:0]  RSTOP10    = 10'(PADDLE_R_X - BALL_SIZE);
    localparam logic [9:0]  SPAWN_X    = 10'(SCREEN_W / 2 - BALL_SIZE / 2);

    localparam logic [4:0]  WIN5       = 5'(WIN_SCORE);
    localparam logic [3:0]  WIN4       = 4'(WIN_SCORE);
    localparam logic [3:0]  SPEED_LO   = 4'(SPEED_MIN);
    localparam logic [3:0]  SPEED_HI   = 4'(SPEED_MAX);
    localparam logic [SERVE_W-1:0] SERVE_LOAD = SERVE_W'(SERVE_TICKS);
    localparam logic [SERVE_W-1:0] SERVE_ONE  = SERVE_W'(1);
    localparam logic [RAMP_W-1:0]  RAMP_LAST  = RAMP_W'(RAMP_TICKS - 1);
    localparam logic [RAMP_W-1:0]  RAMP_ONE   = RAMP_W'(1);

    // Balls are spread evenly down the playfield below the top wall
    function automatic logic [9:0] spawn_y(input int idx);
        return 10'(TOP_MARGIN + (idx + 1) * ((SCREEN_H - TOP_MARGIN) / (NUM_BALLS + 1)));
    endfunction

    // Even balls start heading left and down, odd balls right and up
    function automatic logic spawn_down(input int idx);
        return (idx % 2) == 0;
    endfunction

    game_state_t          state_q;
    logic [9:0]           pos_x     [NUM_BALLS];
    logic [9:0]           pos_y     [NUM_BALLS];
    logic [NUM_BALLS-1:0] dir_right;
    logic [NUM_BALLS-1:0] dir_down;
    logic [SERVE_W-1:0]   serve_cnt [NUM_BALLS];
    logic [RAMP_W-1:0]    ramp_cnt;

    logic [9:0]           next_x    [NUM_BALLS];
    logic [9:0]           next_y    [NUM_BALLS];
    logic [NUM_BALLS-1:0] next_right;
    logic [NUM_BALLS-1:0] next_down;
    logic [NUM_BALLS-1:0] miss_left;
    logic [NUM_BALLS-1:0] miss_right;
    logic [10:0]          step;
    logic [10:0]          p1_top;
    logic [10:0]          p2_top;
    logic [3:0]           misses_left;
    logic [3:0]           misses_right;
    logic [4:0]           sum_p1;
    logic [4:0]           sum_p2;
    logic [3:0]           new_score_p1;
    logic [3:0]           new_score_p2;
    logic                 ramp_wrap;
    logic [3:0]           next_speed;

    assign state = state_q;

    for (genvar g = 0; g < NUM_BALLS; g++) begin : g_pack
        assign ball_x[10*g +: 10] = pos_x[g];
        assign ball_y[10*g +: 10] = pos_y[g];
    end

    // Candidate next position and direction of every ball, in priority order miss, paddle, free move
    always_comb begin
        step   = {7'd0, speed};
        p1_top = {1'b0, paddle1_y} + TOP11;
        p2_top = {1'b0, paddle2_y} + TOP11;
        for (int i = 0; i < NUM_BALLS; i++) begin
            next_x[i]     = pos_x[i];
            next_y[i]     = pos_y[i];
            next_right[i] = dir_right[i];
            next_down[i]  = dir_down[i];
            miss_left[i]  = 1'b0;
            miss_right[i] = 1'b0;

            if (!dir_right[i] && ({1'b0, pos_x[i]} < step)) begin
                miss_left[i] = 1'b1;
            end else if (dir_right[i] && ({1'b0, pos_x[i]} + SIZE11 + step > WIDTH11)) begin
                miss_right[i] = 1'b1;
            end else if (!dir_right[i]
                         && ({1'b0, pos_x[i]} >= LFACE11)
                         && ({1'b0, pos_x[i]} - step < LFACE11)
                         && ({1'b0, pos_y[i]} + SIZE11 > p1_top)
                         && ({1'b0, pos_y[i]} < p1_top + PADH11)) begin
                next_x[i]     = LSTOP10;
                next_right[i] = 1'b1;
            end else if (dir_right[i]
                         && ({1'b0, pos_x[i]} + SIZE11 <= RFACE11)
                         && ({1'b0, pos_x[i]} + SIZE11 + step > RFACE11)
                         && ({1'b0, pos_y[i]} + SIZE11 > p2_top)
                         && ({1'b0, pos_y[i]} < p2_top + PADH11)) begin
                next_x[i]     = RSTOP10;
                next_right[i] = 1'b0;
            end else if (dir_right[i]) begin
                next_x[i] = 10'({1'b0, pos_x[i]} + step);
            end else begin
                next_x[i] = 10'({1'b0, pos_x[i]} - step);
            end

            if (!dir_down[i] && ({1'b0, pos_y[i]} < TOP11 + step)) begin
                next_y[i]    = TOP10;
                next_down[i] = 1'b1;
            end else if (dir_down[i] && ({1'b0, pos_y[i]} + step > BOTTOM11)) begin
                next_y[i]    = BOTTOM10;
                next_down[i] = 1'b0;
            end else if (dir_down[i]) begin
                next_y[i] = 10'({1'b0, pos_y[i]} + step);
            end else begin
                next_y[i] = 10'({1'b0, pos_y[i]} - step);
            end
        end
    end

    // Tally this frame's misses per side and derive saturated scores and the next speed
    always_comb begin
        misses_left  = 4'd0;
        misses_right = 4'd0;
        for (int i = 0; i < NUM_BALLS; i++) begin
            misses_left  = misses_left  + 4'(ball_active[i] & miss_left[i]);
            misses_right = misses_right + 4'(ball_active[i] & miss_right[i]);
        end
        sum_p1       = {1'b0, score_p1} + {1'b0, misses_right};
        sum_p2       = {1'b0, score_p2} + {1'b0, misses_left};
        new_score_p1 = (sum_p1 >= WIN5) ? WIN4 : sum_p1[3:0];
        new_score_p2 = (sum_p2 >= WIN5) ? WIN4 : sum_p2[3:0];
        ramp_wrap    = (ramp_cnt == RAMP_LAST);
        next_speed   = (speed == SPEED_HI) ? SPEED_LO : speed + 4'd1;
    end

    // Game FSM and all frame-advanced state; point pulses self-clear on the following cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            score_p1    <= 4'd0;
            score_p2    <= 4'd0;
            speed       <= SPEED_LO;
            winner      <= 2'b00;
            point_p1    <= 1'b0;
            point_p2    <= 1'b0;
            game_over   <= 1'b0;
            ramp_cnt    <= '0;
            ball_active <= '1;
            for (int i = 0; i < NUM_BALLS; i++) begin
                pos_x[i]     <= SPAWN_X;
                pos_y[i]     <= spawn_y(i);
                dir_right[i] <= ~spawn_down(i);
                dir_down[i]  <= spawn_down(i);
                serve_cnt[i] <= '0;
            end
        end else begin
            point_p1 <= 1'b0;
            point_p2 <= 1'b0;
            if (refresh_tick) begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            state_q     <= PLAY;
                            score_p1    <= 4'd0;
                            score_p2    <= 4'd0;
                            winner      <= 2'b00;
                            ramp_cnt    <= '0;
                            speed       <= SPEED_LO;
                            ball_active <= '1;
                            for (int i = 0; i < NUM_BALLS; i++) begin
                                pos_x[i]     <= SPAWN_X;
                                pos_y[i]     <= spawn_y(i);
                                dir_right[i] <= ~spawn_down(i);
                                dir_down[i]  <= spawn_down(i);
                                serve_cnt[i] <= '0;
                            end
                        end
                    end
                    PLAY: begin
                        if (!pause) begin
                            for (int i = 0; i < NUM_BALLS; i++) begin
                                if (ball_active[i]) begin
                                    if (miss_left[i] || miss_right[i]) begin
                                        ball_active[i] <= 1'b0;
                                        serve_cnt[i]   <= SERVE_LOAD;
                                        pos_x[i]       <= SPAWN_X;
                                        pos_y[i]       <= spawn_y(i);
                                        dir_down[i]    <= spawn_down(i);
                                    end else begin
                                        pos_x[i]     <= next_x[i];
                                        pos_y[i]     <= next_y[i];
                                        dir_right[i] <= next_right[i];
                                        dir_down[i]  <= next_down[i];
                                    end
                                end else if (serve_cnt[i] == SERVE_ONE) begin
                                    ball_active[i] <= 1'b1;
                                    serve_cnt[i]   <= '0;
                                    pos_x[i]       <= SPAWN_X;
                                    pos_y[i]       <= spawn_y(i);
                                end else if (serve_cnt[i] != '0) begin
                                    serve_cnt[i] <= serve_cnt[i] - SERVE_ONE;
                                end
                            end
                            score_p1 <= new_score_p1;
                            score_p2 <= new_score_p2;
                            point_p1 <= (misses_right != 4'd0);
                            point_p2 <= (misses_left != 4'd0);
                            if (ramp_wrap) begin
                                ramp_cnt <= '0;
                                speed    <= next_speed;
                            end else begin
                                ramp_cnt <= ramp_cnt + RAMP_ONE;
                            end
                            if ((new_score_p1 == WIN4) || (new_score_p2 == WIN4)) begin
                                state_q   <= OVER;
                                game_over <= 1'b1;
                                winner    <= {new_score_p2 == WIN4, new_score_p1 == WIN4};
                            end
                        end
                    end
                    OVER: begin
                        if (start) begin
                            state_q   <= IDLE;
                            game_over <= 1'b0;
                        end
                    end
                    default: begin
                        state_q   <= IDLE;
                        game_over <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
